ddr5_cmd_issuer: RTL

DDR5_CMD_ISSUER -- requirements
Module: ddr5_cmd_issuer

---
 rtl/ddr5_cmd_issuer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ddr5_cmd_issuer.sv
// rtl/ddr5_cmd_issuer.sv - in-order open-page DDR5 command issuer with per-bank open-row tracking
module ddr5_cmd_issuer #(
    parameter int T_RCD   = 39,
    parameter int T_RP    = 39,
    parameter int T_RAS   = 76,
    parameter int T_CL    = 40,
    parameter int T_CWL   = 38,
    parameter int T_BURST = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [2:0]  req_bg,
    input  logic [1:0]  req_bank,
    input  logic [15:0] req_row,
    input  logic [9:0]  req_col,
    output logic        cmd_valid,
    output logic [2:0]  cmd_code,
    output logic [2:0]  cmd_bg,
    output logic [1:0]  cmd_bank,
    output logic [15:0] cmd_row,
    output logic [9:0]  cmd_col,
    output logic        done,
    output logic        busy
);

    if (T_RCD < 1 || T_RCD > 255 || T_RP < 1 || T_RP > 255 || T_RAS < 1 || T_RAS > 255 ||
        T_CL < 1 || T_CL > 255 || T_CWL < 1 || T_CWL > 255 || T_BURST < 1 || T_BURST > 255) begin : g_param_check
        $error("ddr5_cmd_issuer: timing parameters must lie in 1..255");
    end

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

    // Counters are loaded with delay-1 on the command edge and fire when they reach zero.
    localparam logic [7:0] RCD_M1   = 8'(T_RCD - 1);
    localparam logic [7:0] RP_M1    = 8'(T_RP - 1);
    localparam logic [7:0] CL_M1    = 8'(T_CL - 1);
    localparam logic [7:0] CWL_M1   = 8'(T_CWL - 1);
    localparam logic [7:0] BURST_M2 = 8'(T_BURST - 2);
    localparam bit         BURST_ONE = (T_BURST == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RAS,
        S_WAIT_RP,
        S_WAIT_RCD,
        S_WAIT_DATA,
        S_DONE
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [1:0]  lat_op;
    logic [2:0]  lat_bg;
    logic [1:0]  lat_bank;
    logic [15:0] lat_row;
    logic [9:0]  lat_col;
    logic [31:0] row_valid;
    logic [15:0] row_tab [32];
    logic [7:0]  ras_cnt;
    logic [7:0]  wait_cnt;
    logic [7:0]  cnt_next;
    logic        burst_phase;
    logic        phase_next;
    logic [2:0]  cmd_sel;
    logic [4:0]  idx;
    logic        row_open;
    logic        row_hit;
    logic [8:0]  ras_elapsed;
    logic        ras_ok;
    logic [2:0]  rw_code;
    logic [7:0]  rw_lat_m1;

    assign idx         = {lat_bg, lat_bank};
    assign row_open    = row_valid[idx];
    assign row_hit     = row_open && (row_tab[idx] == lat_row);
    // The counter holds cycles-since-ACT minus one, so add one before comparing.
    assign ras_elapsed = {1'b0, ras_cnt} + 9'd1;
    assign ras_ok      = ras_elapsed >= 9'(T_RAS);
    assign rw_code     = (lat_op == 2'd1) ? CMD_WR : CMD_RD;
    assign rw_lat_m1   = (lat_op == 2'd1) ? CWL_M1 : CL_M1;

    always_comb begin
        next_state = state;
        cmd_sel    = CMD_NOP;
        cnt_next   = (wait_cnt != 8'd0) ? wait_cnt - 8'd1 : 8'd0;
        phase_next = burst_phase;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!row_open) begin
                    cmd_sel    = CMD_ACT;
                    cnt_next   = RCD_M1;
                    next_state = S_WAIT_RCD;
                end else if (row_hit) begin
                    cmd_sel    = rw_code;
                    cnt_next   = rw_lat_m1;
                    phase_next = 1'b0;
                    next_state = S_WAIT_DATA;
                end else if (ras_ok) begin
                    cmd_sel    = CMD_PRE;
                    cnt_next   = RP_M1;
                    next_state = S_WAIT_RP;
                end else begin
                    next_state = S_WAIT_RAS;
                end
            end
            S_WAIT_RAS: begin
                if (ras_ok) begin
                    cmd_sel    = CMD_PRE;
                    cnt_next   = RP_M1;
                    next_state = S_WAIT_RP;
                end
            end
            S_WAIT_RP: begin
                if (wait_cnt == 8'd0) begin
                    cmd_sel    = CMD_ACT;
                    cnt_next   = RCD_M1;
                    next_state = S_WAIT_RCD;
                end
            end
            S_WAIT_RCD: begin
                if (wait_cnt == 8'd0) begin
                    cmd_sel    = rw_code;
                    cnt_next   = rw_lat_m1;
                    phase_next = 1'b0;
                    next_state = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                // Phase 0 covers CL/CWL, phase 1 the burst; this keeps every counter at 8 bits.
                if (wait_cnt == 8'd0) begin
                    if (burst_phase || BURST_ONE) begin
                        next_state = S_DONE;
                    end else begin
                        phase_next = 1'b1;
                        cnt_next   = BURST_M2;
                    end
                end
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            lat_op      <= 2'd0;
            lat_bg      <= 3'd0;
            lat_bank    <= 2'd0;
            lat_row     <= 16'd0;
            lat_col     <= 10'd0;
            row_valid   <= 32'd0;
            ras_cnt     <= 8'hFF;
            wait_cnt    <= 8'd0;
            burst_phase <= 1'b0;
        end else begin
            state       <= next_state;
            wait_cnt    <= cnt_next;
            burst_phase <= phase_next;
            if (state == S_IDLE && req_valid) begin
                lat_op   <= req_op;
                lat_bg   <= req_bg;
                lat_bank <= req_bank;
                lat_row  <= req_row;
                lat_col  <= req_col;
            end
            if (cmd_sel == CMD_ACT) begin
                ras_cnt        <= 8'd0;
                row_valid[idx] <= 1'b1;
            end else begin
                if (ras_cnt != 8'hFF) begin
                    ras_cnt <= ras_cnt + 8'd1;
                end
                if (cmd_sel == CMD_PRE) begin
                    row_valid[idx] <= 1'b0;
                end
            end
        end
    end

    // Row contents are only meaningful under their valid bit, so they need no reset.
    always_ff @(posedge clock) begin
        if (cmd_sel == CMD_ACT) begin
            row_tab[idx] <= lat_row;
        end
    end

    assign req_ready = (state == S_IDLE) && !reset;
    assign busy      = (state != S_IDLE);
    assign cmd_valid = (cmd_sel != CMD_NOP);
    assign cmd_code  = cmd_sel;
    assign cmd_bg    = cmd_valid ? lat_bg : 3'd0;
    assign cmd_bank  = cmd_valid ? lat_bank : 2'd0;
    assign cmd_row   = (cmd_sel == CMD_ACT) ? lat_row : 16'd0;
    assign cmd_col   = (cmd_sel == CMD_RD || cmd_sel == CMD_WR) ? lat_col : 10'd0;

endmodule
